// File: rtl/display_pkg.sv
// Shared types, segment constants and BCD-to-segment encoding for the
// calculator display scheduler.
package display_pkg;

  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_ENTRY  = 2'd1,
    SRC_RESULT = 2'd2,
    SRC_ERROR  = 2'd3
  } src_e;

  typedef enum logic [2:0] {
    SH_IDLE  = 3'd0,
    SH_LOAD  = 3'd1,
    SH_LO    = 3'd2,
    SH_HI    = 3'd3,
    SH_LATCH = 3'd4
  } sh_state_e;

  localparam logic [7:0]  SEG_DASH    = 8'h02;
  localparam logic [31:0] FRAME_DASH  = 32'h0202_0202;
  localparam logic [31:0] FRAME_BLANK = 32'h0000_0000;

  function automatic logic [7:0] bcd2seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hFC;
      4'd1:    s = 8'h60;
      4'd2:    s = 8'hDA;
      4'd3:    s = 8'hF2;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'hB6;
      4'd6:    s = 8'hBE;
      4'd7:    s = 8'hE0;
      4'd8:    s = 8'hFE;
      4'd9:    s = 8'hF6;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  // Leftmost digit lands in the top byte so it is shifted out last.
  function automatic logic [31:0] bcd2frame(input logic [15:0] bcd);
    return {bcd2seg(bcd[15:12]), bcd2seg(bcd[11:8]), bcd2seg(bcd[7:4]), bcd2seg(bcd[3:0])};
  endfunction

endpackage

// File: rtl/display_sched_seg_shifter.sv
// Bit-serial shifter for one 32-bit segment frame into a 74HC595-style chain,
// finishing with a storage-register latch pulse.
module seg_shifter
  import display_pkg::*;
#(
  parameter int CLK_DIV = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] frame,
  output logic        busy,
  output logic        done,
  output logic        sclk,
  output logic        sdata,
  output logic        latch
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  sh_state_e   state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [4:0]  bit_r, bit_nxt_s;
  logic [31:0] shreg_r, shreg_nxt_s;
  logic        done_s;
  logic        busy_r, sclk_r, sdata_r, latch_r;

  // Next-state, phase counter and shift register update.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    bit_nxt_s   = bit_r;
    shreg_nxt_s = shreg_r;
    done_s      = 1'b0;
    case (state_r)
      SH_IDLE: begin
        if (start) state_nxt_s = SH_LOAD;
        else       state_nxt_s = SH_IDLE;
      end
      SH_LOAD: begin
        shreg_nxt_s = frame;
        cnt_nxt_s   = '0;
        bit_nxt_s   = 5'd0;
        state_nxt_s = SH_LO;
      end
      SH_LO: begin
        if (cnt_r == CNT_LAST) begin
          cnt_nxt_s   = '0;
          state_nxt_s = SH_HI;
        end else begin
          cnt_nxt_s = cnt_r + CW'(1);
        end
      end
      SH_HI: begin
        if (cnt_r == CNT_LAST) begin
          cnt_nxt_s = '0;
          if (bit_r == 5'd31) begin
            state_nxt_s = SH_LATCH;
            done_s      = 1'b1;
          end else begin
            state_nxt_s = SH_LO;
            bit_nxt_s   = bit_r + 5'd1;
            shreg_nxt_s = {1'b0, shreg_r[31:1]};
          end
        end else begin
          cnt_nxt_s = cnt_r + CW'(1);
        end
      end
      SH_LATCH: begin
        if (cnt_r == CNT_LAST) begin
          cnt_nxt_s   = '0;
          state_nxt_s = SH_IDLE;
        end else begin
          cnt_nxt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_nxt_s = SH_IDLE;
        cnt_nxt_s   = '0;
        bit_nxt_s   = 5'd0;
      end
    endcase
  end

  // State register; pin outputs are registered from the next state so they are glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= SH_IDLE;
      cnt_r   <= '0;
      bit_r   <= 5'd0;
      shreg_r <= 32'h0;
      busy_r  <= 1'b0;
      sclk_r  <= 1'b0;
      sdata_r <= 1'b0;
      latch_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      bit_r   <= bit_nxt_s;
      shreg_r <= shreg_nxt_s;
      busy_r  <= (state_nxt_s != SH_IDLE);
      sclk_r  <= (state_nxt_s == SH_HI);
      latch_r <= (state_nxt_s == SH_LATCH);
      sdata_r <= ((state_nxt_s == SH_LO) || (state_nxt_s == SH_HI)) ? shreg_nxt_s[0] : 1'b0;
    end
  end

  assign busy  = busy_r;
  assign done  = done_s;
  assign sclk  = sclk_r;
  assign sdata = sdata_r;
  assign latch = latch_r;

endmodule

// File: rtl/display_sched.sv
// Arbitrates error / result / entry sources onto the 4-digit display and
// drives the serial segment chain through seg_shifter.
module display_sched
  import display_pkg::*;
#(
  parameter int CLK_DIV        = 50,
  parameter int HOLD_CYCLES    = 5_000_000,
  parameter int REFRESH_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        err,
  input  logic        result_valid,
  input  logic [15:0] result_bcd,
  output logic        result_ready,
  input  logic        entry_valid,
  input  logic [15:0] entry_bcd,
  output logic        entry_ready,
  output logic        sclk,
  output logic        sdata,
  output logic        latch,
  output logic        busy,
  output logic [1:0]  shown_src
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(REFRESH_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES);
  localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_CYCLES - 1);

  logic [31:0]   frame_r;
  src_e          pend_src_r, shown_src_r;
  logic [HW-1:0] hold_r;
  logic [RW-1:0] refresh_r;
  logic          start_r, result_ready_r, entry_ready_r;
  logic          sh_busy_s, sh_done_s, idle_s;
  logic          grant_err_s, grant_res_s, grant_ent_s, grant_ref_s, grant_any_s;

  // A start already issued but not yet seen as busy still counts as occupied.
  assign idle_s      = !sh_busy_s && !start_r;
  assign grant_any_s = grant_err_s || grant_res_s || grant_ent_s || grant_ref_s;

  // One arbitration decision per idle cycle; a raised err blocks result and entry.
  always_comb begin
    grant_err_s = 1'b0;
    grant_res_s = 1'b0;
    grant_ent_s = 1'b0;
    grant_ref_s = 1'b0;
    if (!idle_s) begin
      grant_err_s = 1'b0;
    end else if (err && (shown_src_r != SRC_ERROR)) begin
      grant_err_s = 1'b1;
    end else if (!err && result_valid) begin
      grant_res_s = 1'b1;
    end else if (!err && entry_valid && (hold_r == '0)) begin
      grant_ent_s = 1'b1;
    end else if (refresh_r == REF_LAST) begin
      grant_ref_s = 1'b1;
    end else begin
      grant_ref_s = 1'b0;
    end
  end

  // Handshake strobes, shifter start, hold and refresh timers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_r        <= 1'b0;
      result_ready_r <= 1'b0;
      entry_ready_r  <= 1'b0;
      hold_r         <= '0;
      refresh_r      <= '0;
    end else begin
      start_r        <= grant_any_s;
      result_ready_r <= grant_res_s;
      entry_ready_r  <= grant_ent_s;
      if (grant_res_s)        hold_r <= HOLD_INIT;
      else if (hold_r != '0)  hold_r <= hold_r - HW'(1);
      else                    hold_r <= hold_r;
      if (grant_any_s)        refresh_r <= '0;
      else if (idle_s)        refresh_r <= refresh_r + RW'(1);
      else                    refresh_r <= refresh_r;
    end
  end

  // Frame register and source tracking; a refresh re-sends with the current source.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_r     <= FRAME_BLANK;
      pend_src_r  <= SRC_NONE;
      shown_src_r <= SRC_NONE;
    end else begin
      if (grant_err_s) begin
        frame_r    <= FRAME_DASH;
        pend_src_r <= SRC_ERROR;
      end else if (grant_res_s) begin
        frame_r    <= bcd2frame(result_bcd);
        pend_src_r <= SRC_RESULT;
      end else if (grant_ent_s) begin
        frame_r    <= bcd2frame(entry_bcd);
        pend_src_r <= SRC_ENTRY;
      end else if (grant_ref_s) begin
        frame_r    <= frame_r;
        pend_src_r <= shown_src_r;
      end else begin
        frame_r    <= frame_r;
        pend_src_r <= pend_src_r;
      end
      if (sh_done_s) shown_src_r <= pend_src_r;
      else           shown_src_r <= shown_src_r;
    end
  end

  seg_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk  (clk),
    .rst  (rst),
    .start(start_r),
    .frame(frame_r),
    .busy (sh_busy_s),
    .done (sh_done_s),
    .sclk (sclk),
    .sdata(sdata),
    .latch(latch)
  );

  assign busy         = sh_busy_s;
  assign result_ready = result_ready_r;
  assign entry_ready  = entry_ready_r;
  assign shown_src    = shown_src_r;

endmodule

// File: tb/tb_display_sched.sv
// Scoreboard bench for display_sched: stimulus pushes expected frames, a
// negedge monitor reassembles the serial stream and compares at each latch.
module tb_display_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        err = 1'b0;
  logic        result_valid = 1'b0;
  logic [15:0] result_bcd = 16'h0;
  logic        result_ready;
  logic        entry_valid = 1'b0;
  logic [15:0] entry_bcd = 16'h0;
  logic        entry_ready;
  logic        sclk, sdata, latch, busy;
  logic [1:0]  shown_src;

  typedef struct {
    logic [31:0] frame;
    logic [1:0]  src;
  } exp_t;

  exp_t q[$];
  int passed = 0;
  int total = 0;
  int frames_done = 0;
  int latch_cnt = 0;
  int nbits = 0;

  display_sched #(
    .CLK_DIV(2), .HOLD_CYCLES(400), .REFRESH_CYCLES(1000)
  ) dut (
    .clk(clk), .rst(rst), .err(err),
    .result_valid(result_valid), .result_bcd(result_bcd), .result_ready(result_ready),
    .entry_valid(entry_valid), .entry_bcd(entry_bcd), .entry_ready(entry_ready),
    .sclk(sclk), .sdata(sdata), .latch(latch), .busy(busy), .shown_src(shown_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act >= lo && act <= hi) passed++;
    else $display("FAIL %s: actual %0d required %0d..%0d", name, act, lo, hi);
  endtask

  function automatic void push(input logic [31:0] f, input logic [1:0] s);
    exp_t e;
    e.frame = f;
    e.src = s;
    q.push_back(e);
  endfunction

  // Monitor: serial reassembly, latch/busy widths and scoreboard compare.
  logic [31:0] bits = 32'h0;
  logic sclk_q = 1'b0, latch_q = 1'b0, busy_q = 1'b0;
  int busy_len = 0, latch_len = 0;
  always @(negedge clk) begin
    if (!rst) begin
      nbits = 0; busy_len = 0; latch_len = 0;
      sclk_q = 1'b0; latch_q = 1'b0; busy_q = 1'b0;
    end else begin
      if (sclk && !sclk_q) begin
        bits = {sdata, bits[31:1]};
        nbits++;
      end
      if (busy) busy_len++;
      if (!busy && busy_q) begin
        check_range("frame_len", busy_len, 131, 131);
        busy_len = 0;
      end
      if (latch) latch_len++;
      if (latch && !latch_q) begin
        latch_cnt++;
        if (q.size() == 0) begin
          total++;
          $display("FAIL unexpected_frame: actual %h required none", bits);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("frame_bits", bits, e.frame);
          check_range("frame_nbits", nbits, 32, 32);
          check("shown_src_at_latch", {30'h0, shown_src}, {30'h0, e.src});
        end
        nbits = 0;
      end
      if (!latch && latch_q) begin
        check_range("latch_width", latch_len, 2, 2);
        latch_len = 0;
        frames_done++;
      end
      sclk_q = sclk; latch_q = latch; busy_q = busy;
    end
  end

  task automatic wait_ready(input bit use_result, input int budget, output int n);
    logic r;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      r = use_result ? result_ready : entry_ready;
    end while (!r && n < budget);
    check(use_result ? "result_ready_seen" : "entry_ready_seen", {31'h0, r}, 32'h1);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_range("frames_timeout", frames_done, target, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base, lc, stall;
    // Reset state
    repeat (4) @(negedge clk);
    check("rst_sclk", {31'h0, sclk}, 32'h0);
    check("rst_sdata", {31'h0, sdata}, 32'h0);
    check("rst_latch", {31'h0, latch}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_shown", {30'h0, shown_src}, 32'h0);
    check("rst_rready", {31'h0, result_ready}, 32'h0);
    check("rst_eready", {31'h0, entry_ready}, 32'h0);
    rst = 1'b1;

    // 1: entry 1234
    entry_valid = 1'b1; entry_bcd = 16'h1234;
    wait_ready(1'b0, 10, n);
    push(32'h60DAF266, 2'd1);
    entry_valid = 1'b0;
    @(negedge clk);
    check("entry_ready_width", {31'h0, entry_ready}, 32'h0);
    wait_frames(1, 200);
    check("t1_shown", {30'h0, shown_src}, 32'h1);

    // 2: result 0009, entry held through hold time
    @(negedge clk);
    result_valid = 1'b1; result_bcd = 16'h0009;
    wait_ready(1'b1, 10, n);
    push(32'hFCFCFCF6, 2'd2);
    result_valid = 1'b0;
    entry_valid = 1'b1; entry_bcd = 16'h0001;
    wait_ready(1'b0, 600, n);
    check_range("hold_release", n, 400, 401);
    push(32'hFCFCFC60, 2'd1);
    entry_valid = 1'b0;
    wait_frames(3, 300);

    // 3: err mid-frame of 5555
    @(negedge clk);
    entry_valid = 1'b1; entry_bcd = 16'h5555;
    wait_ready(1'b0, 10, n);
    push(32'hB6B6B6B6, 2'd1);
    entry_valid = 1'b0;
    repeat (20) @(negedge clk);
    err = 1'b1;
    push(32'h02020202, 2'd3);
    entry_valid = 1'b1; entry_bcd = 16'h1111;
    wait_frames(5, 400);
    stall = 0;
    repeat (100) begin
      @(negedge clk);
      if (entry_ready) stall++;
    end
    check_range("err_stall", stall, 0, 0);
    check("t3_shown_err", {30'h0, shown_src}, 32'h3);
    err = 1'b0;
    wait_ready(1'b0, 20, n);
    push(32'h60606060, 2'd1);
    entry_valid = 1'b0;
    wait_frames(6, 300);

    // 4: result and entry in the same idle cycle
    @(negedge clk);
    result_valid = 1'b1; result_bcd = 16'h0042;
    entry_valid = 1'b1; entry_bcd = 16'h0777;
    wait_ready(1'b1, 10, n);
    check("result_priority", {31'h0, entry_ready}, 32'h0);
    push(32'hFCFC66DA, 2'd2);
    result_valid = 1'b0;
    wait_ready(1'b0, 600, n);
    check_range("hold_release_t4", n, 400, 401);
    push(32'hFCE0E0E0, 2'd1);
    entry_valid = 1'b0;
    wait_frames(8, 300);

    // 5: A0F9 then idle refresh
    @(negedge clk);
    entry_valid = 1'b1; entry_bcd = 16'hA0F9;
    wait_ready(1'b0, 10, n);
    push(32'h02FC02F6, 2'd1);
    entry_valid = 1'b0;
    wait_frames(9, 300);
    push(32'h02FC02F6, 2'd1);
    n = 0;
    while (!busy && n < 1100) begin
      @(negedge clk);
      n++;
    end
    check_range("refresh_gap", n, 995, 1005);
    wait_frames(10, 300);
    check("t5_shown", {30'h0, shown_src}, 32'h1);

    // 6: reset during bit 10
    @(negedge clk);
    entry_valid = 1'b1; entry_bcd = 16'h1234;
    wait_ready(1'b0, 10, n);
    entry_valid = 1'b0;
    n = 0;
    while (nbits < 10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_range("abort_reach_bit10", nbits, 10, 10);
    repeat (2) @(negedge clk);
    lc = latch_cnt;
    base = frames_done;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_sclk", {31'h0, sclk}, 32'h0);
    check("abort_latch", {31'h0, latch}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_shown", {30'h0, shown_src}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (300) @(negedge clk);
    check_range("abort_no_latch", latch_cnt, lc, lc);
    check_range("abort_no_frame", frames_done, base, base);
    check_range("queue_empty", q.size(), 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
